// File: rtl/seg7_pkg.sv
// Shared types, segment glyph table and decode helper for the 7-segment scan controller.
package seg7_pkg;

  // Segment pattern {g,f,e,d,c,b,a}, active low
  typedef logic [6:0] seg7_t;

  localparam seg7_t SEG7_BLANK = 7'h7F;

  localparam seg7_t SEG7_DEC [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } scan_state_t;

  function automatic seg7_t seg7_decode(input logic [3:0] nibble);
    return SEG7_DEC[nibble];
  endfunction

endpackage

// File: rtl/seg7_tick_gen.sv
// Slot timebase: counts 0..REFRESH_DIV-1 and flags the blanking window and the last cycle of a slot.
module seg7_tick_gen #(
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned BLANK_CYC   = 500
) (
  input  logic clk,
  input  logic rst,
  output logic in_blank,
  output logic in_blank_next,
  output logic slot_end
);

  localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  logic [CNT_W-1:0] tick_cnt;
  logic [CNT_W-1:0] tick_cnt_next;

  // Wrap at the end of the slot; in_blank_next lets the owner register outputs without a lag cycle.
  always_comb begin
    slot_end      = (tick_cnt == CNT_W'(REFRESH_DIV - 1));
    tick_cnt_next = slot_end ? '0 : tick_cnt + CNT_W'(1);
    in_blank      = (tick_cnt < CNT_W'(BLANK_CYC));
    in_blank_next = (tick_cnt_next < CNT_W'(BLANK_CYC));
  end

  // Slot counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt_next;
    end
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan controller for common-anode 7-segment digits on a shared segment bus.
// Accepts a packed hex word via valid/ready, double-buffers it and commits only at frame boundaries.
// Optional build macro SEG7_LZ_BLANK_EN: suppress leading zeros (digit 0 is always shown).
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned BLANK_CYC   = 500
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  output seg7_t                   seg_n,
  output logic [NUM_DIGITS-1:0]   digit_en_n,
  output logic                    frame_done
);

  localparam int unsigned IDX_W = $clog2(NUM_DIGITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  scan_state_t state;
  scan_state_t state_next;

  logic [IDX_W-1:0]        digit_idx;
  logic [IDX_W-1:0]        idx_next;
  logic [4*NUM_DIGITS-1:0] disp;
  logic [4*NUM_DIGITS-1:0] disp_next;
  logic [4*NUM_DIGITS-1:0] pend;
  logic                    pend_v;
  logic                    pend_v_next;

  logic                    in_blank;
  logic                    in_blank_next;
  logic                    slot_end;
  logic                    frame_end;
  logic                    accept;

  seg7_t                   seg_next;
  logic [NUM_DIGITS-1:0]   en_next;
  logic [3:0]              nib;
  logic                    dark;

  seg7_tick_gen #(
    .REFRESH_DIV (REFRESH_DIV),
    .BLANK_CYC   (BLANK_CYC)
  ) u_tick (
    .clk           (clk),
    .rst           (rst),
    .in_blank      (in_blank),
    .in_blank_next (in_blank_next),
    .slot_end      (slot_end)
  );

  assign load_ready = !pend_v;
  assign accept     = load_valid && load_ready;
  assign frame_end  = slot_end && (digit_idx == LAST_IDX);

  // State register: scan phase and active digit
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= BLANK;
      digit_idx <= '0;
    end else begin
      state     <= state_next;
      digit_idx <= idx_next;
    end
  end

  // Next-state: phase follows the slot counter, digit advances at slot end
  always_comb begin
    state_next = in_blank_next ? BLANK : SHOW;
    idx_next   = digit_idx;
    if (slot_end) begin
      idx_next = (digit_idx == LAST_IDX) ? '0 : digit_idx + IDX_W'(1);
    end
  end

  // Buffer update: a word accepted on the boundary cycle lands in pend and waits a full frame,
  // since pend_v was clear so there is nothing to commit this time.
  always_comb begin
    disp_next   = disp;
    pend_v_next = pend_v;
    if (frame_end && pend_v) begin
      disp_next   = pend;
      pend_v_next = 1'b0;
    end
    if (accept) begin
      pend_v_next = 1'b1;
    end
  end

  // Buffer registers
  always_ff @(posedge clk) begin
    if (rst) begin
      disp   <= '0;
      pend   <= '0;
      pend_v <= 1'b0;
    end else begin
      disp   <= disp_next;
      pend_v <= pend_v_next;
      if (accept) begin
        pend <= value_in;
      end
    end
  end

  // Output decode from next-state values so the registered pins line up with the current state
  always_comb begin
    seg_next = SEG7_BLANK;
    en_next  = '1;
    nib      = '0;
    dark     = 1'b0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (idx_next == IDX_W'(i)) begin
        nib = disp_next[4*i +: 4];
      end
    end
`ifdef SEG7_LZ_BLANK_EN
    for (int unsigned i = 1; i < NUM_DIGITS; i++) begin
      if ((idx_next == IDX_W'(i)) && ((disp_next >> (4*i)) == '0)) begin
        dark = 1'b1;
      end
    end
`else
    dark = 1'b0;
`endif
    if ((state_next == SHOW) && !dark) begin
      en_next[idx_next] = 1'b0;
      seg_next          = seg7_decode(nib);
    end
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_n      <= SEG7_BLANK;
      digit_en_n <= '1;
      frame_done <= 1'b0;
    end else begin
      seg_n      <= seg_next;
      digit_en_n <= en_next;
      frame_done <= frame_end;
    end
  end

  a_phase_tracks_tick: assert property (@(posedge clk) disable iff (rst)
    ((state == BLANK) == in_blank));

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl: a frame-arithmetic reference model predicts every cycle's
// outputs into a queue; a negedge monitor pops and compares.
module tb_seg7_scan_ctrl;

  localparam int unsigned ND    = 4;
  localparam int unsigned RD    = 8;
  localparam int unsigned BC    = 2;
  localparam int unsigned FRAME = ND * RD;
`ifdef SEG7_LZ_BLANK_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_valid = 1'b0;
  logic [15:0] value_in = '0;
  logic        load_ready;
  logic [6:0]  seg_n;
  logic [3:0]  digit_en_n;
  logic        frame_done;

  seg7_scan_ctrl #(
    .NUM_DIGITS  (ND),
    .REFRESH_DIV (RD),
    .BLANK_CYC   (BC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .value_in   (value_in),
    .seg_n      (seg_n),
    .digit_en_n (digit_en_n),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0] seg;
    logic [3:0] en;
    logic       ready;
    logic       fd;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model state: cycles since reset, shown word, pending word
  int unsigned t = 0;
  logic [15:0] m_disp = '0;
  logic [15:0] m_pend = '0;
  logic        m_pv = 1'b0;

  logic [6:0] glyph [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  function automatic exp_t predict();
    exp_t        e;
    int unsigned tick;
    int unsigned dig;
    logic [3:0]  n;
    logic [15:0] upper;
    tick    = t % RD;
    dig     = (t / RD) % ND;
    n       = m_disp[4*dig +: 4];
    upper   = m_disp >> (4*dig);
    e.seg   = 7'h7F;
    e.en    = 4'hF;
    e.ready = !m_pv;
    e.fd    = (t != 0) && (t % FRAME == 0);
    if (tick >= BC && !(LZ && dig != 0 && upper == 16'h0)) begin
      e.en[dig] = 1'b0;
      e.seg     = glyph[n];
    end
    return e;
  endfunction

  task automatic step(input logic r, input logic v, input logic [15:0] val);
    logic acc;
    rst        = r;
    load_valid = v;
    value_in   = val;
    @(posedge clk);
    if (r) begin
      t      = 0;
      m_disp = '0;
      m_pv   = 1'b0;
    end else begin
      acc = v && !m_pv;
      if ((t % FRAME == FRAME - 1) && m_pv) begin
        m_disp = m_pend;
        m_pv   = 1'b0;
      end
      if (acc) begin
        m_pend = val;
        m_pv   = 1'b1;
      end
      t++;
    end
    exp_q.push_back(predict());
    #1;
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) step(1'b0, 1'b0, 16'($urandom));
  endtask

  task automatic load_word(input logic [15:0] val);
    int unsigned waited = 0;
    while (m_pv && waited < 200) begin
      step(1'b0, 1'b1, val);
      waited++;
    end
    step(1'b0, 1'b1, val);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s t=%0d actual=%h required=%h", name, t, act, req);
    end
  endtask

  exp_t mon_e;

  // Monitor: compare every presented cycle against the queued prediction
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("seg_n",      32'(seg_n),      32'(mon_e.seg));
      check("digit_en_n", 32'(digit_en_n), 32'(mon_e.en));
      check("load_ready", 32'(load_ready), 32'(mon_e.ready));
      check("frame_done", 32'(frame_done), 32'(mon_e.fd));
    end
  end

  initial begin
    int unsigned guard;
    logic [15:0] rv;

    // Reset and an idle frame showing zeros
    repeat (3) step(1'b1, 1'b0, 16'h0);
    idle(45);

    // Mid-frame load, committed at the next boundary
    load_word(16'h1A3F);
    idle(70);

    // Second word held while the first is still pending
    load_word(16'h2468);
    load_word(16'hBEEF);
    idle(80);

    // Accept exactly on the boundary cycle
    guard = 0;
    while (((t % FRAME) != FRAME - 1 || m_pv) && guard < 200) begin
      idle(1);
      guard++;
    end
    step(1'b0, 1'b1, 16'h0005);
    idle(70);

    // Leading-zero patterns
    load_word(16'h0050);
    idle(70);
    load_word(16'h0000);
    idle(70);
    load_word(16'h7C9D);
    idle(70);

    // Reset during SHOW of digit 2
    guard = 0;
    while ((t % FRAME) != 2*RD + 4 && guard < 200) begin
      idle(1);
      guard++;
    end
    step(1'b1, 1'b0, 16'h0);
    idle(40);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 2500; i++) begin
      rv = 16'($urandom) >> (4 * $urandom_range(0, 4));
      step(($urandom_range(0, 599) == 0), ($urandom_range(0, 2) == 0), rv);
    end

    idle(1);
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
